// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one 16-bit external memory port between a one-entry
//            32-bit instruction fetch buffer and the core's data accesses,
//            with big-endian byte-lane steering on the data side.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int DATA_PRIORITY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] i_mem_pc,
   output logic [31:0] i_mem_opcode,
   output logic        i_mem_rdy,
   input  logic        d_mem_assert,
   input  logic        d_mem_cmd,
   input  logic        d_mem_be0,
   input  logic        d_mem_be1,
   input  logic [15:0] d_mem_addr,
   input  logic [15:0] d_mem_data_out,
   output logic [15:0] d_mem_data_in,
   output logic        d_mem_rdy,
   output logic        m_req,
   output logic        m_we,
   output logic [1:0]  m_be,
   output logic [15:0] m_addr,
   output logic [15:0] m_wdata,
   input  logic [15:0] m_rdata,
   input  logic        m_ack
);

   localparam logic c_DATA_FIRST = (DATA_PRIORITY != 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_I_HI   = 3'd1,
      S_I_LO   = 3'd2,
      S_D_ACC  = 3'd3,
      S_D_DONE = 3'd4
   } t_state;

   t_state      r_state;
   logic        r_valid;
   logic [13:0] r_tag;
   logic [13:0] r_ftag;
   logic        r_word;
   logic        r_lane;
   logic [31:0] r_opcode;
   logic [15:0] r_din;
   logic        r_drdy;
   logic        r_req;
   logic        r_we;
   logic [1:0]  r_be;
   logic [15:0] r_addr;
   logic [15:0] r_wdata;

   logic        w_hit;
   logic        w_word;
   logic        w_take_data;
   logic        w_take_fetch;
   logic [15:0] w_rd_steer;
   logic        w_wr_hits_buf;

   // Buffer hit is combinational on the current fetch address
   assign w_hit         = r_valid && (r_tag == i_mem_pc[15:2]);
   assign w_word        = d_mem_be0 && d_mem_be1;
   // Arbitration in IDLE: a data request wins unless instruction priority is
   // configured and the fetch buffer misses
   assign w_take_data   = d_mem_assert && (c_DATA_FIRST || w_hit);
   assign w_take_fetch  = !w_hit && !w_take_data;
   // Even byte lives in bits 15:8 (big-endian), odd byte in bits 7:0
   assign w_rd_steer    = r_word ? m_rdata :
                          (r_lane ? {8'h00, m_rdata[7:0]} : {8'h00, m_rdata[15:8]});
   // A data write landing in the buffered pair makes the buffer stale
   assign w_wr_hits_buf = r_we && (r_addr[15:2] == r_tag);

   // Sequencer: arbitration, external port drive and buffer/result capture
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_valid  <= 1'b0;
         r_tag    <= 14'd0;
         r_ftag   <= 14'd0;
         r_word   <= 1'b0;
         r_lane   <= 1'b0;
         r_opcode <= 32'd0;
         r_din    <= 16'd0;
         r_drdy   <= 1'b0;
         r_req    <= 1'b0;
         r_we     <= 1'b0;
         r_be     <= 2'b00;
         r_addr   <= 16'd0;
         r_wdata  <= 16'd0;
      end else begin
         r_drdy <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_take_data) begin
                  r_state <= S_D_ACC;
                  r_req   <= 1'b1;
                  r_we    <= d_mem_cmd;
                  r_word  <= w_word;
                  r_lane  <= d_mem_addr[0];
                  r_addr  <= {d_mem_addr[15:1], 1'b0};
                  r_be    <= w_word ? 2'b11 : (d_mem_addr[0] ? 2'b01 : 2'b10);
                  if (d_mem_cmd) begin
                     r_wdata <= w_word ? d_mem_data_out
                                       : {d_mem_data_out[7:0], d_mem_data_out[7:0]};
                  end
               end else if (w_take_fetch) begin
                  // Buffer is invalid while being refilled so a half-written
                  // pair can never be reported as a hit
                  r_state <= S_I_HI;
                  r_valid <= 1'b0;
                  r_ftag  <= i_mem_pc[15:2];
                  r_req   <= 1'b1;
                  r_we    <= 1'b0;
                  r_be    <= 2'b11;
                  r_addr  <= {i_mem_pc[15:2], 2'b00};
               end
            end
            S_I_HI: begin
               if (m_ack) begin
                  r_opcode[31:16] <= m_rdata;
                  r_addr          <= {r_ftag, 2'b10};
                  r_state         <= S_I_LO;
               end
            end
            S_I_LO: begin
               if (m_ack) begin
                  r_opcode[15:0] <= m_rdata;
                  r_tag          <= r_ftag;
                  r_valid        <= 1'b1;
                  r_req          <= 1'b0;
                  r_state        <= S_IDLE;
               end
            end
            S_D_ACC: begin
               if (m_ack) begin
                  if (!r_we) begin
                     r_din <= w_rd_steer;
                  end
                  if (w_wr_hits_buf) begin
                     r_valid <= 1'b0;
                  end
                  r_req   <= 1'b0;
                  r_drdy  <= 1'b1;
                  r_state <= S_D_DONE;
               end
            end
            S_D_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign i_mem_rdy     = w_hit;
   assign i_mem_opcode  = r_opcode;
   assign d_mem_data_in = r_din;
   assign d_mem_rdy     = r_drdy;
   assign m_req         = r_req;
   assign m_we          = r_we;
   assign m_be          = r_be;
   assign m_addr        = r_addr;
   assign m_wdata       = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter: a word-addressed RAM
//            with programmable ack delay, an expected-access queue, per-cycle
//            port/buffer invariants and directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

   typedef struct {
      logic [15:0] addr;
      logic        we;
      logic [1:0]  be;
      logic [15:0] wd;
      bit          chk_be;
      bit          chk_wd;
   } acc_t;

   logic        clk;
   logic        rst;
   logic [15:0] i_mem_pc;
   logic [31:0] i_mem_opcode;
   logic        i_mem_rdy;
   logic        d_mem_assert;
   logic        d_mem_cmd;
   logic        d_mem_be0;
   logic        d_mem_be1;
   logic [15:0] d_mem_addr;
   logic [15:0] d_mem_data_out;
   logic [15:0] d_mem_data_in;
   logic        d_mem_rdy;
   logic        m_req;
   logic        m_we;
   logic [1:0]  m_be;
   logic [15:0] m_addr;
   logic [15:0] m_wdata;
   logic [15:0] m_rdata;
   logic        m_ack;

   // second instance, instruction priority, read-only zero-wait port
   logic [15:0] pc0;
   logic [31:0] op0;
   logic        irdy0;
   logic        da0;
   logic [15:0] daddr0;
   logic [15:0] din0;
   logic        drdy0;
   logic        mreq0;
   logic        mwe0;
   logic [1:0]  mbe0;
   logic [15:0] maddr0;
   logic [15:0] mwd0;
   logic [15:0] mrd0;
   logic        mack0;

   logic [15:0] mem [0:32767];
   int          ack_wait;
   int          wcnt;
   bit          loaded;
   acc_t        expq[$];
   logic [15:0] mdl_din;
   int          n_tests;
   int          n_fail;
   bit          mon_en;
   logic        rst_q;
   logic [34:0] prev_bus;
   logic        prev_req;
   logic        prev_ack;
   logic        prev_drdy;
   acc_t        me;

   mem_port_arbiter #(.DATA_PRIORITY(1)) dut (
      .clk(clk), .rst(rst),
      .i_mem_pc(i_mem_pc), .i_mem_opcode(i_mem_opcode), .i_mem_rdy(i_mem_rdy),
      .d_mem_assert(d_mem_assert), .d_mem_cmd(d_mem_cmd),
      .d_mem_be0(d_mem_be0), .d_mem_be1(d_mem_be1),
      .d_mem_addr(d_mem_addr), .d_mem_data_out(d_mem_data_out),
      .d_mem_data_in(d_mem_data_in), .d_mem_rdy(d_mem_rdy),
      .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack)
   );

   mem_port_arbiter #(.DATA_PRIORITY(0)) dut0 (
      .clk(clk), .rst(rst),
      .i_mem_pc(pc0), .i_mem_opcode(op0), .i_mem_rdy(irdy0),
      .d_mem_assert(da0), .d_mem_cmd(1'b0),
      .d_mem_be0(1'b1), .d_mem_be1(1'b1),
      .d_mem_addr(daddr0), .d_mem_data_out(16'h0000),
      .d_mem_data_in(din0), .d_mem_rdy(drdy0),
      .m_req(mreq0), .m_we(mwe0), .m_be(mbe0), .m_addr(maddr0),
      .m_wdata(mwd0), .m_rdata(mrd0), .m_ack(mack0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM slave: ack after ack_wait extra cycles, lane-masked writes
   assign m_ack   = m_req && (wcnt == ack_wait);
   assign m_rdata = mem[m_addr[15:1]];
   assign mack0   = mreq0;
   assign mrd0    = mem[maddr0[15:1]];

   always @(posedge clk) begin
      if (!loaded) begin
         loaded     <= 1'b1;
         mem[16'h0] <= 16'h1790;  mem[16'h1]  <= 16'h0000;
         mem[16'h8] <= 16'hBEEF;  mem[16'h9]  <= 16'hCAFE;
         mem[16'h20] <= 16'h1111; mem[16'h21] <= 16'h2222;
         mem[16'h40] <= 16'h3333; mem[16'h41] <= 16'h4444;
         mem[16'h50] <= 16'h0000; mem[16'h51] <= 16'h1234;
      end
      if (rst) begin
         wcnt <= 0;
      end else if (m_req) begin
         if (m_ack) begin
            wcnt <= 0;
            if (m_we && m_be[1]) mem[m_addr[15:1]][15:8] <= m_wdata[15:8];
            if (m_we && m_be[0]) mem[m_addr[15:1]][7:0]  <= m_wdata[7:0];
         end else begin
            wcnt <= wcnt + 1;
         end
      end
   end

   always @(posedge clk) rst_q <= rst;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: no response within cycle budget", name);
   endtask

   // Per-cycle checks: accesses in predicted order, port stability and hold,
   // buffer contents equal to RAM whenever reported valid, single rdy pulse
   always @(negedge clk) begin
      if (mon_en && rst_q === 1'b0) begin
         if (m_req && m_ack) begin
            if (expq.size() == 0) begin
               fail_now("unexpected_access");
            end else begin
               me = expq.pop_front();
               chk("acc_addr", 64'(m_addr), 64'(me.addr));
               chk("acc_we", 64'(m_we), 64'(me.we));
               if (me.chk_be) chk("acc_be", 64'(m_be), 64'(me.be));
               if (me.chk_wd) chk("acc_wdata", 64'(m_wdata), 64'(me.wd));
            end
         end
         if (m_req) chk("addr_align", 64'(m_addr[0]), 64'(1'b0));
         if (!m_req || (prev_req && !prev_ack))
            chk("bus_stable", 64'({m_we, m_be, m_addr, m_wdata}), 64'(prev_bus));
         if (i_mem_rdy)
            chk("opcode_coherent", 64'(i_mem_opcode),
                64'({mem[{i_mem_pc[15:2], 1'b0}], mem[{i_mem_pc[15:2], 1'b1}]}));
         if (d_mem_rdy) begin
            chk("drdy_single", 64'(prev_drdy), 64'(1'b0));
            chk("drdy_requested", 64'(d_mem_assert), 64'(1'b1));
         end
      end
      prev_bus  <= {m_we, m_be, m_addr, m_wdata};
      prev_req  <= m_req;
      prev_ack  <= m_ack;
      prev_drdy <= d_mem_rdy;
   end

   task automatic push_fetch(input logic [15:0] pc);
      acc_t e;
      e.addr = {pc[15:2], 2'b00}; e.we = 1'b0; e.be = 2'b11; e.wd = 16'h0;
      e.chk_be = 1'b1; e.chk_wd = 1'b0;
      expq.push_back(e);
      e.addr = {pc[15:2], 2'b10};
      expq.push_back(e);
   endtask

   // Cycles from now (caller is just past a rising edge) until i_mem_rdy
   task automatic wait_irdy(output int lat);
      lat = 0;
      forever begin
         @(negedge clk);
         if (i_mem_rdy) break;
         if (lat >= 60) begin fail_now("fetch_timeout"); break; end
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic data_op(input bit we, input bit b0, input bit b1, input logic [15:0] a,
                          input logic [15:0] dout, input int exp_lat, input bit use_lit,
                          input logic [15:0] lit, output bit ir_done);
      acc_t        e;
      logic [15:0] w;
      int          lat;
      bit          word;
      word     = b0 & b1;
      w        = mem[a[15:1]];
      e.addr   = {a[15:1], 1'b0};
      e.we     = we;
      e.be     = word ? 2'b11 : (a[0] ? 2'b01 : 2'b10);
      e.wd     = word ? dout : {dout[7:0], dout[7:0]};
      e.chk_be = word | we;
      e.chk_wd = we;
      expq.push_back(e);
      if (!we) mdl_din = word ? w : (a[0] ? {8'h00, w[7:0]} : {8'h00, w[15:8]});
      @(posedge clk); #1;
      d_mem_assert = 1'b1; d_mem_cmd = we; d_mem_be0 = b0; d_mem_be1 = b1;
      d_mem_addr = a; d_mem_data_out = dout;
      lat = 0;
      forever begin
         @(negedge clk);
         if (d_mem_rdy) break;
         if (lat >= 60) begin fail_now("data_timeout"); break; end
         @(posedge clk); #1;
         lat++;
      end
      chk("data_lat", 64'(lat), 64'(exp_lat));
      chk("data_in", 64'(d_mem_data_in), 64'(mdl_din));
      if (use_lit) chk("data_lit", 64'(d_mem_data_in), 64'(lit));
      ir_done = i_mem_rdy;
      @(posedge clk); #1;
      d_mem_assert = 1'b0;
   endtask

   // Fetch miss and data read raised in the same cycle on both instances
   task automatic prio_run(input logic [15:0] pc, input logic [15:0] a,
                           input int exp_dl, input int exp_il, input bit use0);
      acc_t e;
      int   dl, il, dl0, il0, first0;
      logic [15:0] a0, dd0;
      e.addr = a; e.we = 1'b0; e.be = 2'b11; e.wd = 16'h0; e.chk_be = 1'b1; e.chk_wd = 1'b0;
      expq.push_back(e);
      push_fetch(pc);
      mdl_din = mem[a[15:1]];
      dl = -1; il = -1; dl0 = -1; il0 = -1; first0 = -1; a0 = 16'h0; dd0 = 16'h0;
      @(posedge clk); #1;
      i_mem_pc = pc; d_mem_assert = 1'b1; d_mem_cmd = 1'b0; d_mem_be0 = 1'b1;
      d_mem_be1 = 1'b1; d_mem_addr = a;
      if (use0) begin pc0 = pc; da0 = 1'b1; daddr0 = a; end
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (d_mem_rdy && dl < 0) begin dl = c; chk("prio_din", 64'(d_mem_data_in), 64'(mdl_din)); end
         if (i_mem_rdy && il < 0) il = c;
         if (use0) begin
            if (mreq0 && first0 < 0) begin first0 = c; a0 = maddr0; end
            if (drdy0 && dl0 < 0) begin dl0 = c; dd0 = din0; end
            if (irdy0 && il0 < 0) il0 = c;
         end
         if (dl >= 0 && il >= 0 && (!use0 || (dl0 >= 0 && il0 >= 0))) break;
         @(posedge clk); #1;
         if (dl >= 0) d_mem_assert = 1'b0;
         if (dl0 >= 0) da0 = 1'b0;
      end
      @(posedge clk); #1;
      d_mem_assert = 1'b0; da0 = 1'b0;
      chk("prio_data_lat", 64'(dl), 64'(exp_dl));
      chk("prio_fetch_lat", 64'(il), 64'(exp_il));
      if (use0) begin
         chk("ipri_first_req_cycle", 64'(first0), 64'(1));
         chk("ipri_first_req_addr", 64'(a0), 64'(pc));
         chk("ipri_fetch_lat", 64'(il0), 64'(3));
         chk("ipri_data_lat", 64'(dl0), 64'(5));
         chk("ipri_data_in", 64'(dd0), 64'(16'hC000));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      bit ird;
      n_tests = 0; n_fail = 0; mon_en = 1'b0; loaded = 1'b0;
      ack_wait = 0; mdl_din = 16'h0000;
      rst = 1'b1; i_mem_pc = 16'h0000; d_mem_assert = 1'b0; d_mem_cmd = 1'b0;
      d_mem_be0 = 1'b0; d_mem_be1 = 1'b0; d_mem_addr = 16'h0; d_mem_data_out = 16'h0;
      pc0 = 16'h0000; da0 = 1'b0; daddr0 = 16'h0;
      repeat (3) @(posedge clk);

      // reset state
      @(negedge clk);
      chk("rst_irdy", 64'(i_mem_rdy), 64'(0));
      chk("rst_opcode", 64'(i_mem_opcode), 64'(0));
      chk("rst_drdy", 64'(d_mem_rdy), 64'(0));
      chk("rst_din", 64'(d_mem_data_in), 64'(0));
      chk("rst_bus", 64'({m_req, m_we, m_be, m_addr, m_wdata}), 64'(0));
      mon_en = 1'b1;

      // first fetch from pc 0 right out of reset, then a hit on pc 2
      push_fetch(16'h0000);
      @(posedge clk); #1;
      rst = 1'b0;
      wait_irdy(lat);
      chk("fetch0_lat", 64'(lat), 64'(3));
      chk("fetch0_opcode", 64'(i_mem_opcode), 64'(32'h17900000));
      @(posedge clk); #1;
      i_mem_pc = 16'h0002;
      wait_irdy(lat);
      chk("hit_lat", 64'(lat), 64'(0));
      chk("hit_no_req", 64'(m_req), 64'(0));
      @(posedge clk); #1;
      @(negedge clk);
      chk("hit_no_req2", 64'(m_req), 64'(0));

      // word write / read
      data_op(1'b1, 1'b1, 1'b1, 16'h00A0, 16'hC000, 2, 1'b0, 16'h0, ird);
      data_op(1'b0, 1'b1, 1'b1, 16'h00A0, 16'h0000, 2, 1'b1, 16'hC000, ird);

      // byte write to the odd lane, then byte reads of both lanes
      data_op(1'b1, 1'b1, 1'b0, 16'h00A3, 16'h775A, 2, 1'b0, 16'h0, ird);
      chk("byte_write_ram", 64'(mem[16'h51]), 64'(16'h125A));
      data_op(1'b0, 1'b0, 1'b1, 16'h00A2, 16'h0000, 2, 1'b1, 16'h0012, ird);
      data_op(1'b0, 1'b1, 1'b0, 16'h00A3, 16'h0000, 2, 1'b1, 16'h005A, ird);

      // simultaneous miss + data: zero wait, then three wait cycles per access
      prio_run(16'h0040, 16'h00A0, 2, 6, 1'b1);
      ack_wait = 3;
      prio_run(16'h0080, 16'h00A0, 5, 15, 1'b0);
      chk("prio_delayed_opcode", 64'(i_mem_opcode), 64'(32'h33334444));
      ack_wait = 0;

      // pc moves during I_HI: first pair still completes, then a second fetch
      push_fetch(16'h0000);
      push_fetch(16'h0010);
      @(posedge clk); #1;
      i_mem_pc = 16'h0000;
      @(posedge clk); #1;
      i_mem_pc = 16'h0010;
      wait_irdy(lat);
      chk("refetch_lat", 64'(lat), 64'(5));
      chk("refetch_opcode", 64'(i_mem_opcode), 64'(32'hBEEFCAFE));

      // write into the buffered pair invalidates it and forces a refetch
      push_fetch(16'h0010);
      expq.push_front('{addr: 16'h0012, we: 1'b1, be: 2'b11, wd: 16'h1357, chk_be: 1'b1, chk_wd: 1'b1});
      data_op(1'b1, 1'b1, 1'b1, 16'h0012, 16'h1357, 2, 1'b0, 16'h0, ird);
      // data_op pushed its own copy at the tail; drop that duplicate
      if (expq.size() > 0) void'(expq.pop_back());
      chk("coherence_invalid", 64'(ird), 64'(0));
      wait_irdy(lat);
      chk("coherence_refetch_lat", 64'(lat), 64'(3));
      chk("coherence_opcode", 64'(i_mem_opcode), 64'(32'hBEEF1357));
      chk("expq_drained", 64'(expq.size()), 64'(0));

      // reset while a data access waits for ack
      ack_wait = 5;
      @(posedge clk); #1;
      d_mem_assert = 1'b1; d_mem_cmd = 1'b0; d_mem_be0 = 1'b1; d_mem_be1 = 1'b1;
      d_mem_addr = 16'h00A0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_req_up", 64'(m_req), 64'(1));
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      d_mem_assert = 1'b0;
      @(negedge clk);
      chk("abort_req_dropped", 64'(m_req), 64'(0));
      chk("abort_no_drdy", 64'(d_mem_rdy), 64'(0));
      chk("abort_irdy", 64'(i_mem_rdy), 64'(0));
      repeat (2) begin
         @(negedge clk);
         chk("abort_no_drdy_later", 64'(d_mem_rdy), 64'(0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one 16-bit external memory port between the core's instruction fetch side and its data side.
- Instruction side: holds a one-entry 32-bit fetch buffer. On a miss it fetches two 16-bit words and presents them as i_mem_opcode.
- Data side: serves the core's d_mem_* word and byte accesses, doing big-endian byte-lane steering.
- Placement: between core and a single RAM/bus slave, so a unified memory can replace the split banks.

Parameters:
DATA_PRIORITY, 1, when both sides need the port in IDLE: 1 = data wins, 0 = instruction wins.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
i_mem_pc  in  16  core fetch byte address; bits [1:0] ignored
i_mem_opcode  out  32  fetched pair, {word@pc&~3, word@(pc&~3)+2}
i_mem_rdy  out  1  i_mem_opcode valid for current i_mem_pc
d_mem_assert  in  1  data request, held until d_mem_rdy
d_mem_cmd  in  1  1 = write, 0 = read
d_mem_be0  in  1  byte enable 0
d_mem_be1  in  1  byte enable 1
d_mem_addr  in  16  data byte address
d_mem_data_out  in  16  write data from core
d_mem_data_in  out  16  read data to core
d_mem_rdy  out  1  one-cycle completion pulse
m_req  out  1  external request, held until m_ack
m_we  out  1  external write strobe
m_be  out  2  lane enables; [1] = bits 15:8 (even byte), [0] = bits 7:0 (odd byte)
m_addr  out  16  word-aligned byte address, bit 0 always 0
m_wdata  out  16  external write data
m_rdata  in  16  external read data, valid in m_ack cycle
m_ack  in  1  external completion; may be high in the first m_req cycle

Behaviour:
- Reset: all outputs 0, fetch buffer invalid (valid = 0, tag = 0), state IDLE. A reset during an external access drops m_req at that edge; the in-flight access is abandoned and no rdy is issued.
- Hit rule: i_mem_rdy = valid & (tag == i_mem_pc[15:2]), combinational on i_mem_pc; i_mem_opcode is registered.
- States:
  - IDLE: a miss is i_mem_rdy = 0. A data request is d_mem_assert = 1.
    - Both pending: choose per DATA_PRIORITY.
    - Miss only: latch ftag = i_mem_pc[15:2], go to I_HI.
    - Data only: latch addr/cmd/be/data, go to D_ACC.
  - I_HI: m_req = 1, m_we = 0, m_be = 11, m_addr = {ftag, 2'b00}. On m_ack: opcode[31:16] <= m_rdata, go to I_LO.
  - I_LO: same as I_HI, but m_addr = {ftag, 2'b10}. On m_ack: opcode[15:0] <= m_rdata, tag <= ftag, valid <= 1, go to IDLE.
  - D_ACC: m_req = 1, m_we = latched cmd. On m_ack: register the read result, go to D_DONE.
  - D_DONE: d_mem_rdy = 1 for exactly this cycle, and d_mem_data_in updates on entry. No request is accepted; next state IDLE.
- Fetch atomicity: a fetch always completes both words, even if i_mem_pc changes mid-fetch; the buffer takes ftag. A resulting mismatch re-misses from IDLE. Data waits until the fetch finishes.
- Word access (be0 & be1): m_addr = {addr[15:1], 0}, m_be = 11. Write: m_wdata = data_out. Read: data_in = m_rdata.
- Byte access (not both enables set):
  - Write: m_wdata = {data_out[7:0], data_out[7:0]}; m_be = 10 if addr[0] = 0, else 01.
  - Read: data_in = {8'h00, m_rdata[15:8]} if addr[0] = 0, else {8'h00, m_rdata[7:0]}.
- Coherence: a completed data write with addr[15:2] == tag clears valid in D_DONE.
- Latency, zero-wait memory:
  - Fetch: miss seen at cycle 0, m_req cycles 1–2, i_mem_rdy at cycle 3.
  - Data: assert at cycle 0, m_req cycle 1, d_mem_rdy cycle 2.
  - Each wait cycle of m_ack adds one cycle.
- m_addr, m_we, m_be and m_wdata are stable whenever m_req = 1. When m_req = 0 they hold their last values.
- d_mem_data_in holds until the next read completes; writes leave it unchanged.

Test Plan:
- Reset then pc = 0x0000, memory word0 = 0x1790, word1 = 0x0000, zero-wait → i_mem_rdy rises at cycle 3, opcode = 0x17900000. pc = 0x0002 → still hit, no m_req.
- Word write 0xC000 to 0x00A0, then word read 0x00A0 → m_be = 11, m_addr = 0x00A0; d_mem_rdy pulses once per access; data_in = 0xC000.
- Byte write 0x5A to 0x00A3, then byte reads 0x00A2 and 0x00A3 (word preloaded 0x1234) → write has m_be = 01, m_wdata = 0x5A5A; reads return 0x0012 and 0x005A.
- Simultaneous miss and data read, DATA_PRIORITY = 1 → D_ACC first. With DATA_PRIORITY = 0 the fetch goes first. Repeat with m_ack delayed 3 cycles → latencies grow by 3 per access.
- pc changes from 0x0000 to 0x0010 during I_HI → pair at 0x0000 completes, then a second fetch at 0x0010. Write to 0x0012 while tag = 0x0004 → valid drops, refetch follows.
- Assert rst during D_ACC with m_ack low → m_req = 0 next cycle, no d_mem_rdy, i_mem_rdy = 0.
